// File: rtl/mem_word_reader_if.sv
// Request/result and halfword-memory signals of the word reader, bundled as one port.
// The reader uses the slave view; the requester together with the memory uses the master view.
interface mem_word_reader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] byte_addr;
    logic              big_endian;
    logic              busy;
    logic              done;
    logic [31:0]       data;
    logic              misaligned;
    logic [ADDR_W-2:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata;

    modport slave (
        input  start,
        input  byte_addr,
        input  big_endian,
        input  mem_rdata,
        output busy,
        output done,
        output data,
        output misaligned,
        output mem_addr,
        output mem_rd
    );

    modport master (
        output start,
        output byte_addr,
        output big_endian,
        output mem_rdata,
        input  busy,
        input  done,
        input  data,
        input  misaligned,
        input  mem_addr,
        input  mem_rd
    );
endinterface

// File: rtl/mem_word_reader.sv
// Fetches a 32-bit word at any byte address from a 16-bit synchronous memory
// using two (even address) or three (odd address) halfword reads.
module mem_word_reader #(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_word_reader_if.slave   bus
);
    localparam int HW_W = ADDR_W - 1;
    localparam logic [HW_W-1:0] HW_ONE = {{(HW_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_COLLECT = 2'd2
    } state_t;

    state_t            state_r;
    logic              busy_r;
    logic              done_r;
    logic              mem_rd_r;
    logic              misaligned_r;
    logic [HW_W-1:0]   mem_addr_r;
    logic [31:0]       data_r;
    logic              odd_r;
    logic              be_r;
    logic [1:0]        issued_r;
    logic [31:0]       collect_r;

    logic [47:0]       collect_s;
    logic [31:0]       word_s;
    logic [31:0]       assembled_s;
    logic [1:0]        last_s;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Assemble the word from the collected halfwords plus the one arriving now
    always_comb begin
        collect_s   = {collect_r, bus.mem_rdata};
        word_s      = 32'h0000_0000;
        assembled_s = 32'h0000_0000;
        last_s      = 2'd1;
        // An odd start address skips the leading high byte of the first halfword
        if (odd_r) begin
            word_s = collect_s[39:8];
            last_s = 2'd2;
        end else begin
            word_s = collect_s[31:0];
            last_s = 2'd1;
        end
        if (be_r) begin
            assembled_s = word_s;
        end else begin
            assembled_s = byte_swap(word_s);
        end
    end

    // Access sequencer: accept, issue halfword reads, collect, publish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mem_rd_r     <= 1'b0;
            misaligned_r <= 1'b0;
            mem_addr_r   <= {HW_W{1'b0}};
            data_r       <= 32'h0000_0000;
            odd_r        <= 1'b0;
            be_r         <= 1'b0;
            issued_r     <= 2'd0;
            collect_r    <= 32'h0000_0000;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        be_r         <= bus.big_endian;
                        odd_r        <= bus.byte_addr[0];
                        misaligned_r <= |bus.byte_addr[1:0];
                        mem_addr_r   <= bus.byte_addr[ADDR_W-1:1];
                        mem_rd_r     <= 1'b1;
                        busy_r       <= 1'b1;
                        issued_r     <= 2'd0;
                        state_r      <= ST_READ;
                    end else begin
                        mem_rd_r     <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    // Read data lags its strobe by one edge, so nothing arrives at the first edge
                    if (issued_r != 2'd0) begin
                        collect_r <= {collect_r[15:0], bus.mem_rdata};
                    end else begin
                        collect_r <= collect_r;
                    end
                    issued_r <= issued_r + 2'd1;
                    if (issued_r == last_s) begin
                        mem_rd_r <= 1'b0;
                        state_r  <= ST_COLLECT;
                    end else begin
                        mem_addr_r <= mem_addr_r + HW_ONE;
                        state_r    <= ST_READ;
                    end
                end
                ST_COLLECT: begin
                    data_r  <= assembled_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_rd_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.data       = data_r;
    assign bus.misaligned = misaligned_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_rd     = mem_rd_r;

endmodule

// File: tb/tb_mem_word_reader.sv
// Randomized scoreboard bench for mem_word_reader with a byte-level reference model
// and a halfword memory model with one-cycle read latency.
module tb_mem_word_reader;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_word_reader_if #(.ADDR_W(ADDR_W)) bus();

    mem_word_reader #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        mis;
        int          done_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] addr_q[$];
    logic [7:0] mem_bytes [256];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         noise = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: halfword h = {byte 2h, byte 2h+1}, data one cycle after the strobe
    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1)
            bus.mem_rdata <= {mem_bytes[{bus.mem_addr, 1'b0}], mem_bytes[{bus.mem_addr, 1'b1}]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a, input bit be);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = mem_bytes[8'(a + k)];
        return be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
    endfunction

    // Monitor: memory addresses and completed words against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (bus.mem_rd === 1'b1) begin
                    check("rd_while_busy", 32'(bus.busy), 32'd1);
                    if (addr_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
                    else check("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
                end
                if (bus.done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("data", bus.data, e.data);
                        check("misaligned", 32'(bus.misaligned), 32'(e.mis));
                        check("done_latency", 32'(cyc), 32'(e.done_cyc));
                        check("busy_at_done", 32'(bus.busy), 32'd0);
                        check("reads_issued", 32'(addr_q.size()), 32'd0);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (bus.busy !== 1'b0 && guard < 40) begin
            if (noise) begin
                bus.start      = 1'($urandom_range(0, 1));
                bus.byte_addr  = 8'($urandom);
                bus.big_endian = 1'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic access(input logic [7:0] a, input bit be);
        exp_t e;
        int   n;
        wait_idle();
        n = a[0] ? 3 : 2;
        bus.start      = 1'b1;
        bus.byte_addr  = a;
        bus.big_endian = be;
        e.data     = ref_word(a, be);
        e.mis      = (a[1:0] != 2'b00);
        e.done_cyc = cyc + n + 2;
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) addr_q.push_back(7'((a >> 1) + k));
        @(negedge clk);
        bus.start      = 1'b0;
        bus.byte_addr  = 8'($urandom);
        bus.big_endian = 1'($urandom);
    endtask

    task automatic check_zero(input string name);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_done"}, 32'(bus.done), 32'd0);
        check({name, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        check({name, "_misaligned"}, 32'(bus.misaligned), 32'd0);
        check({name, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({name, "_data"}, bus.data, 32'h0000_0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'(i);
        bus.start      = 1'b0;
        bus.byte_addr  = 8'h00;
        bus.big_endian = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        access(8'h00, 1'b1); wait_idle();
        check("aligned_be", bus.data, 32'h0001_0203);
        check("aligned_mis", 32'(bus.misaligned), 32'd0);
        access(8'h00, 1'b0); wait_idle();
        check("aligned_le", bus.data, 32'h0302_0100);
        access(8'h05, 1'b1); wait_idle();
        check("odd_be", bus.data, 32'h0506_0708);
        check("odd_mis", 32'(bus.misaligned), 32'd1);
        access(8'h06, 1'b1); wait_idle();
        check("half_be", bus.data, 32'h0607_0809);
        check("half_mis", 32'(bus.misaligned), 32'd1);
        access(8'hFE, 1'b1); wait_idle();
        check("wrap_even", bus.data, 32'hFEFF_0001);
        access(8'hFF, 1'b0); wait_idle();
        check("wrap_odd", bus.data, 32'h0201_00FF);

        // A start pulse during an access must be ignored
        access(8'h00, 1'b1);
        bus.start = 1'b1; bus.byte_addr = 8'h10; bus.big_endian = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        check("ignored_start", bus.data, 32'h0001_0203);
        repeat (3) @(negedge clk);

        // Back-to-back acceptances
        access(8'h01, 1'b1);
        access(8'h02, 1'b0);
        access(8'h03, 1'b1);
        wait_idle();

        // Reset in the middle of an access
        access(8'h04, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        access(8'h04, 1'b1); wait_idle();
        check("after_reset", bus.data, 32'h0405_0607);

        // Random contents, addresses, byte orders and start noise while busy
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom);
        noise = 1'b1;
        for (int t = 0; t < 300; t++) access(8'($urandom), 1'($urandom));
        wait_idle();
        noise = 1'b0;
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("addr_q_empty", 32'(addr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
